// File: rtl/pcf_key_debounce.sv
// Debounces the active-low pin read-back of the pcf8575 expander into clean levels,
// press/release pulses and sticky press flags that drive an interrupt line.
module pcf_key_debounce #(
    parameter int WIDTH      = 16,
    parameter int TICK_DIV   = 8000,
    parameter int STABLE_CNT = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rdata,
    input  logic             ack,
    input  logic [WIDTH-1:0] ack_mask,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] event_pend,
    output logic             irq
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [WIDTH-1:0] INV_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ack_clr;
    logic [WIDTH-1:0] pend_next;
    logic [CW-1:0]    cnt_q    [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];

    assign tick = (tick_cnt == TICK_LAST);
    assign raw  = rdata ^ INV_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A single tick where raw agrees with the debounced level throws away any progress.
    always_comb begin
        state_next = state;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt_q[i];
            if (tick) begin
                if (raw[i] == state[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    state_next[i] = raw[i];
                    cnt_next[i]   = '0;
                end else begin
                    cnt_next[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise    = state_next & ~state;
    assign fall    = ~state_next & state;
    assign ack_clr = ack ? ack_mask : '0;

    // Flags show up together with the press pulse, and the pulse keeps them set
    // against an ack landing in the same cycle.
    assign pend_next = (event_pend & ~ack_clr) | rise | press_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            event_pend    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state         <= state_next;
            press_pulse   <= rise;
            release_pulse <= fall;
            event_pend    <= pend_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

    assign irq = |event_pend;

endmodule

// File: tb/tb_pcf_key_debounce.sv
// Scoreboard bench for pcf_key_debounce: the stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_pcf_key_debounce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rdata = 16'hFFFF;
    logic        ack = 1'b0;
    logic [15:0] ack_mask = 16'h0000;
    logic [15:0] state;
    logic [15:0] press_pulse;
    logic [15:0] release_pulse;
    logic [15:0] event_pend;
    logic        irq;

    typedef struct {
        int          cyc;
        logic [15:0] st;
        logic [15:0] pp;
        logic [15:0] rp;
        logic [15:0] ep;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    pcf_key_debounce #(
        .WIDTH(16),
        .TICK_DIV(4),
        .STABLE_CNT(3),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdata(rdata),
        .ack(ack),
        .ack_mask(ack_mask),
        .state(state),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .event_pend(event_pend),
        .irq(irq)
    );

    task automatic pushExpect(input logic [15:0] st, input logic [15:0] pp, input logic [15:0] rp,
                              input logic [15:0] ep, input logic ir);
        exp_t e;
        e.cyc = cyc;
        e.st  = st;
        e.pp  = pp;
        e.rp  = rp;
        e.ep  = ep;
        e.irq = ir;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs just after the edge and record what the outputs must show now.
    task automatic applyStimulus(input logic [15:0] rd, input logic a, input logic [15:0] m,
                                 input logic [15:0] st, input logic [15:0] pp, input logic [15:0] rp,
                                 input logic [15:0] ep, input logic ir);
        @(posedge clk);
        #1;
        cyc++;
        rdata    = rd;
        ack      = a;
        ack_mask = m;
        pushExpect(st, pp, rp, ep, ir);
    endtask

    task automatic hold(input int n, input logic [15:0] rd, input logic [15:0] st,
                        input logic [15:0] ep, input logic ir);
        repeat (n) applyStimulus(rd, 1'b0, 16'h0000, st, 16'h0000, 16'h0000, ep, ir);
    endtask

    // Reset is raised between edges so the monitor sees the clear before any clock edge.
    task automatic doReset(input logic [15:0] rd, input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rdata    = rd;
        ack      = 1'b0;
        ack_mask = 16'h0000;
        cyc      = -1;
        pushExpect(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            pushExpect(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pushExpect(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic checkOutput(input string name, input int c, input logic [15:0] act,
                               input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("state", mon_e.cyc, state, mon_e.st);
            checkOutput("press_pulse", mon_e.cyc, press_pulse, mon_e.pp);
            checkOutput("release_pulse", mon_e.cyc, release_pulse, mon_e.rp);
            checkOutput("event_pend", mon_e.cyc, event_pend, mon_e.ep);
            checkOutput("irq", mon_e.cyc, {15'h0000, irq}, {15'h0000, mon_e.irq});
        end
    end

    initial begin
        // Idle after reset: nothing pressed, nothing moves.
        doReset(16'hFFFF, 3);
        hold(100, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

        // Bit0 pressed from cycle 0; ticks sample cycles 3, 7, 11.
        doReset(16'hFFFE, 2);
        hold(11, 16'hFFFE, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(16'hFFFE, 1'b0, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1'b1);
        hold(2, 16'hFFFE, 16'h0001, 16'h0001, 1'b1);

        // Bit1 bounce: low 2 ticks, high 1 tick, low 2 ticks, then a 3rd low tick.
        hold(8, 16'hFFFC, 16'h0001, 16'h0001, 1'b1);
        hold(4, 16'hFFFE, 16'h0001, 16'h0001, 1'b1);
        hold(9, 16'hFFFC, 16'h0001, 16'h0001, 1'b1);
        applyStimulus(16'hFFFC, 1'b0, 16'h0000, 16'h0003, 16'h0002, 16'h0000, 16'h0003, 1'b1);

        // Masked acks clear only the selected flags.
        applyStimulus(16'hFFFC, 1'b1, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 1'b1);
        applyStimulus(16'hFFFC, 1'b1, 16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0001, 1'b1);

        // Release bit0 alone, then press it again with an ack landing on the pulse.
        hold(9, 16'hFFFD, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(16'hFFFD, 1'b0, 16'h0000, 16'h0002, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        hold(11, 16'hFFFC, 16'h0002, 16'h0000, 1'b0);
        applyStimulus(16'hFFFC, 1'b1, 16'h0001, 16'h0003, 16'h0001, 16'h0000, 16'h0001, 1'b1);
        applyStimulus(16'hFFFC, 1'b1, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0001, 1'b1);

        // Release both bits together; the pending flag must survive.
        hold(10, 16'hFFFF, 16'h0003, 16'h0001, 1'b1);
        applyStimulus(16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0001, 1'b1);
        hold(3, 16'hFFFF, 16'h0000, 16'h0001, 1'b1);

        // Two ticks of a bit0 press, then reset throws the partial count away.
        hold(9, 16'hFFFE, 16'h0000, 16'h0001, 1'b1);
        doReset(16'hFFFE, 2);
        hold(11, 16'hFFFE, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(16'hFFFE, 1'b0, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1'b1);
        hold(3, 16'hFFFE, 16'h0001, 16'h0001, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d left required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pcf_key_debounce.md
Name: pcf_key_debounce

Overview:
Consumer stage directly downstream of the pcf8575 I2C expander driver, running on the same 800 kHz system clock. It takes the expander's 16-bit `rdata` read-back, where pins are pulled high and a pressed or active pin reads 0. Each bit is debounced on a slow sample tick, and the block produces a clean level vector, one-cycle press/release pulses and sticky press-event flags. An `irq` line is asserted while any press event is pending, and an ack-with-mask interface clears the flags.

Parameters:
- WIDTH, 16, number of expander pins handled.
- TICK_DIV, 8000, clk cycles per sample tick (8000 at 800 kHz gives a 10 ms tick).
- STABLE_CNT, 3, consecutive differing samples required before a bit changes state; legal range is ≥1.
- ACTIVE_LOW, 1, when 1 the raw input is inverted so that a pin reading 0 is logical "pressed" = 1.

Ports:
- clk, input, 1, system clock (800 kHz domain).
- rst, input, 1, reset.
- rdata, input, WIDTH, raw pin levels from the pcf8575 driver, same clock domain, sampled with no synchronizer.
- ack, input, 1, single-cycle strobe that clears pending events.
- ack_mask, input, WIDTH, bits of `event_pend` to clear when `ack` = 1.
- state, output, WIDTH, debounced logical level (1 = pressed/active).
- press_pulse, output, WIDTH, one-cycle pulse per bit on a debounced 0→1 transition.
- release_pulse, output, WIDTH, one-cycle pulse per bit on a debounced 1→0 transition.
- event_pend, output, WIDTH, sticky press flags.
- irq, output, 1, equals the OR of all `event_pend` bits.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high. All registers clear immediately on `rst` = 1, independent of `clk`.
- Reset values:
  - `state` = 0, `press_pulse` = 0, `release_pulse` = 0, `event_pend` = 0, `irq` = 0.
  - Tick counter = 0; all per-bit debounce counters = 0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is asserted for the one cycle in which counter = TICK_DIV-1.
  - TICK_DIV = 1 gives `tick` every cycle.
- Raw value: raw[i] = rdata[i] XOR ACTIVE_LOW.
- Per-bit debounce, evaluated only on `tick` cycles:
  - If raw[i] == state[i]: cnt[i] ← 0.
  - Else if cnt[i] == STABLE_CNT-1: state[i] ← raw[i], cnt[i] ← 0, and a pulse is generated.
  - Else: cnt[i] ← cnt[i]+1.
  - Width of cnt is clog2(STABLE_CNT), minimum 1 bit.
  - With STABLE_CNT = 1, the bit follows raw on the first differing tick.
- Latency:
  - A raw change first sampled at tick k updates `state` at the register edge ending the tick cycle of tick k+STABLE_CNT-1.
  - Any single tick where raw equals `state` resets that bit's progress (bounce rejection).
- Pulses:
  - `press_pulse[i]` / `release_pulse[i]` are registered and high for exactly one clk cycle, the same cycle the new `state[i]` value first appears.
  - Outside those cycles both are 0.
  - Several bits may pulse in the same cycle.
- Event flags:
  - `event_pend[i]` is set by `press_pulse[i]`.
  - It is cleared when `ack` = 1 and `ack_mask[i]` = 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - `ack` with `ack_mask` = 0 has no effect.
  - Release does not touch `event_pend`.
- irq: combinational OR of the `event_pend` register, with no added latency.
- Reset mid-operation: partial counts are discarded. After reset, a held input needs a full STABLE_CNT ticks, counted from a fresh tick counter, before `state` changes.
- Bit independence: bits are fully independent; there is no cross-bit interaction.

Test Plan:
Bench parameters for all scenarios: TICK_DIV = 4, STABLE_CNT = 3, ACTIVE_LOW = 1.
1. Reset with `rdata` = 16'hFFFF and 100 cycles idle: `state` = 0, all pulses 0, `event_pend` = 0, `irq` = 0 throughout.
2. Press: `rdata` = 16'hFFFE held from cycle 0.
   - `state` = 16'h0001 after the 3rd tick (cycle 12).
   - `press_pulse` = 16'h0001 for exactly 1 cycle.
   - `event_pend` = 16'h0001 and `irq` = 1 from that cycle.
3. Bounce: bit1 low for 2 ticks, then high for 1 tick, then low for 2 ticks: `state[1]` stays 0 and no pulse occurs. Holding bit1 low for a 3rd tick then sets `state[1]`.
4. Ack:
   - `ack` = 1 with `ack_mask` = 16'h0001 → `event_pend` = 0 and `irq` = 0 the next cycle.
   - Repeat with `ack` coinciding with a new bit0 press pulse → `event_pend[0]` stays 1.
5. Release: `rdata` back to 16'hFFFF → `release_pulse` = 16'h0001 for 1 cycle after 3 ticks, `state` = 0, and a pending `event_pend` bit is unchanged.
6. Reset mid-count: hold `rdata` = 16'hFFFE, assert `rst` asynchronously after 2 ticks, then release.
   - All outputs are 0 immediately.
   - `state[0]` rises only 3 full ticks after reset deassertion.
